// File: rtl/sdram_req_scheduler.sv
// sdram_req_scheduler
//   Arbitrates three masters onto one 16-bit Avalon-style SDRAM bridge, with one
//   transaction in flight at a time. The fixed priority is audio (A) > init writer (I) > video (V).
//   If V has been held off by I for STARVE_LIMIT cycles, V is promoted above I.
//
// Ports
//   clk, reset_n                 system clock, asynchronous active-low reset
//   a_req/a_addr -> a_ack/a_rdata              audio read port
//   i_req/i_addr/i_wdata/i_be -> i_ack         init write port
//   v_req/v_addr -> v_ack/v_rdata              video read port
//   bridge_address/byte_enable/read/write/write_data -> bridge (byte address = {word,0})
//   bridge_acknowledge/bridge_read_data        completion strobe and read data from bridge
//   grant_id   0 none, 1 A, 2 I, 3 V (current or last owner)
//   busy       high while not IDLE
//   stall_err  sticky: an ISSUE phase lasted TIMEOUT_CYC cycles
module sdram_req_scheduler #(
    parameter int unsigned ADDR_W       = 25,
    parameter int unsigned STARVE_LIMIT = 64,
    parameter int unsigned TIMEOUT_CYC  = 4096
) (
    input  logic              clk,
    input  logic              reset_n,

    input  logic              a_req,
    input  logic [ADDR_W-1:0] a_addr,
    output logic              a_ack,
    output logic [15:0]       a_rdata,

    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [15:0]       i_wdata,
    input  logic [1:0]        i_be,
    output logic              i_ack,

    input  logic              v_req,
    input  logic [ADDR_W-1:0] v_addr,
    output logic              v_ack,
    output logic [15:0]       v_rdata,

    output logic [ADDR_W:0]   bridge_address,
    output logic [1:0]        bridge_byte_enable,
    output logic              bridge_read,
    output logic              bridge_write,
    output logic [15:0]       bridge_write_data,
    input  logic              bridge_acknowledge,
    input  logic [15:0]       bridge_read_data,

    output logic [1:0]        grant_id,
    output logic              busy,
    output logic              stall_err
);

    localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);
    localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
    localparam logic [TW-1:0] TO_MAX     = TW'(TIMEOUT_CYC);
    localparam logic [TW-1:0] TO_LAST    = TW'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_A    = 2'd1,
        OWN_I    = 2'd2,
        OWN_V    = 2'd3
    } owner_t;

    state_t        state, state_next;
    owner_t        winner;
    logic [SW-1:0] starve_cnt;
    logic [TW-1:0] timeout_cnt;
    logic          i_cycle;
    logic          v_granted;

    // Arbitration; it only takes effect in IDLE.
    always_comb begin
        winner = OWN_NONE;
        if (a_req)
            winner = OWN_A;
        else if (v_req && (starve_cnt == STARVE_MAX))
            winner = OWN_V;
        else if (i_req)
            winner = OWN_I;
        else if (v_req)
            winner = OWN_V;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= ST_IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (winner != OWN_NONE) state_next = ST_ISSUE;
            ST_ISSUE: if (bridge_acknowledge) state_next = ST_DONE;
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bridge_address     <= '0;
            bridge_byte_enable <= '0;
            bridge_read        <= 1'b0;
            bridge_write       <= 1'b0;
            bridge_write_data  <= '0;
            a_ack              <= 1'b0;
            i_ack              <= 1'b0;
            v_ack              <= 1'b0;
            a_rdata            <= '0;
            v_rdata            <= '0;
            grant_id           <= '0;
            busy               <= 1'b0;
            timeout_cnt        <= '0;
            stall_err          <= 1'b0;
        end else begin
            a_ack <= 1'b0;
            i_ack <= 1'b0;
            v_ack <= 1'b0;
            busy  <= (state_next != ST_IDLE);
            case (state)
                ST_IDLE: begin
                    if (winner != OWN_NONE) begin
                        grant_id    <= winner;
                        timeout_cnt <= '0;
                        case (winner)
                            OWN_A: begin
                                bridge_address     <= {a_addr, 1'b0};
                                bridge_byte_enable <= 2'b11;
                                bridge_read        <= 1'b1;
                            end
                            OWN_I: begin
                                bridge_address     <= {i_addr, 1'b0};
                                bridge_byte_enable <= i_be;
                                bridge_write_data  <= i_wdata;
                                bridge_write       <= 1'b1;
                            end
                            default: begin
                                bridge_address     <= {v_addr, 1'b0};
                                bridge_byte_enable <= 2'b11;
                                bridge_read        <= 1'b1;
                            end
                        endcase
                    end
                end
                ST_ISSUE: begin
                    if (timeout_cnt != TO_MAX)
                        timeout_cnt <= timeout_cnt + TW'(1);
                    if (timeout_cnt == TO_LAST)
                        stall_err <= 1'b1;
                    if (bridge_acknowledge) begin
                        bridge_read  <= 1'b0;
                        bridge_write <= 1'b0;
                        case (grant_id)
                            OWN_A: begin
                                a_rdata <= bridge_read_data;
                                a_ack   <= 1'b1;
                            end
                            OWN_I: i_ack <= 1'b1;
                            OWN_V: begin
                                v_rdata <= bridge_read_data;
                                v_ack   <= 1'b1;
                            end
                            default: ;
                        endcase
                    end
                end
                default: ;
            endcase
        end
    end

    // V starves while I is winning or owns the bus. Audio traffic leaves the count untouched.
    assign i_cycle   = ((state == ST_IDLE) && (winner == OWN_I)) ||
                       ((state != ST_IDLE) && (grant_id == OWN_I));
    assign v_granted = (state == ST_IDLE) && (winner == OWN_V);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            starve_cnt <= '0;
        else if (!v_req || v_granted)
            starve_cnt <= '0;
        else if (i_cycle && (starve_cnt != STARVE_MAX))
            starve_cnt <= starve_cnt + SW'(1);
    end

endmodule
